gpio_pwm_ctrl: RTL

- Register-programmable controller that drives the 8-pin tri-state IO buffer block in the GPIO_PWM design.
- Generates that block's Output[7:0] and Mode[15:0] buses, with a per-pin choice of input, static output or PWM output.
- Provides a shared prescaled PWM timebase, per-pin duty registers that update glitch-free at period boundaries, and synchronized pin readback.
- Sits between the host register bus and the IO buffer.

---
 rtl/gpio_pwm_ctrl_pkg.sv | 30 +++
 rtl/gpio_pwm_ctrl_pwm_channel.sv | 31 +++
 rtl/gpio_pwm_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gpio_pwm_ctrl_pkg.sv
// Shared constants for the GPIO/PWM controller: sizes, register map and pin mode codes.
package gpio_pwm_ctrl_pkg;

  localparam int unsigned NPINS = 8;
  localparam int unsigned PRE_W = 8;

  localparam logic [3:0] ADDR_MODE_LO    = 4'h0;
  localparam logic [3:0] ADDR_MODE_HI    = 4'h1;
  localparam logic [3:0] ADDR_OUT_STATIC = 4'h2;
  localparam logic [3:0] ADDR_PRESCALE   = 4'h3;
  localparam logic [3:0] ADDR_DUTY0      = 4'h4;
  localparam logic [3:0] ADDR_DUTY7      = 4'hB;
  localparam logic [3:0] ADDR_PIN_IN     = 4'hC;
  localparam logic [3:0] ADDR_STATUS     = 4'hD;

  // Per-pin mode as {pwm_select, drive_enable}
  localparam logic [1:0] MODE_IN   = 2'b00;
  localparam logic [1:0] MODE_OUT  = 2'b01;
  localparam logic [1:0] MODE_RSVD = 2'b10;
  localparam logic [1:0] MODE_PWM  = 2'b11;

  function automatic logic is_duty_addr(logic [3:0] addr);
    return (addr >= ADDR_DUTY0) && (addr <= ADDR_DUTY7);
  endfunction

  function automatic logic [2:0] duty_index(logic [3:0] addr);
    return 3'(addr - ADDR_DUTY0);
  endfunction

endpackage

// File: rtl/gpio_pwm_ctrl_pwm_channel.sv
// One PWM channel: active duty register reloaded from its shadow at period wrap, compared to the
// shared counter.
module gpio_pwm_ctrl_pwm_channel (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] duty_shadow_i,
  input  logic [7:0] cnt_i,
  input  logic       wrap_i,
  output logic       pwm_o
);

  logic [7:0] duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (wrap_i) begin
      duty_d = duty_shadow_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign pwm_o = (cnt_i < duty_q);

endmodule

// File: rtl/gpio_pwm_ctrl.sv
// Register-programmable driver for the 8-pin tri-state IO buffer: per-pin input/static/PWM mode,
// shared prescaled PWM timebase and synchronized pin readback.
module gpio_pwm_ctrl
  import gpio_pwm_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Wr_En,
  input  logic        Rd_En,
  input  logic [3:0]  Addr,
  input  logic [7:0]  Wr_Data,
  output logic [7:0]  Rd_Data,
  output logic        Rd_Valid,
  input  logic [7:0]  Pin_In,
  output logic [7:0]  Output,
  output logic [15:0] Mode,
  output logic        Period_Tick
);

  logic [15:0]      mode_q, mode_d;
  logic [7:0]       out_static_q, out_static_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_q [NPINS];
  logic [7:0]       duty_d [NPINS];
  logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic             status_q, status_d;
  logic             period_tick_q, period_tick_d;
  logic [7:0]       output_q, output_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             tick, wrap;
  logic [7:0]       rd_mux;
  logic [NPINS-1:0] pwm;

  // Timebase; a prescale count already past a newly written PRESCALE restarts without a tick.
  always_comb begin
    tick          = (pre_cnt_q == prescale_q);
    wrap          = tick && (cnt_q == 8'hFF);
    pre_cnt_d     = (pre_cnt_q >= prescale_q) ? '0 : pre_cnt_q + PRE_W'(1);
    cnt_d         = tick ? cnt_q + 8'd1 : cnt_q;
    period_tick_d = wrap;
  end

  always_comb begin
    mode_d       = mode_q;
    out_static_d = out_static_q;
    prescale_d   = prescale_q;
    duty_d       = duty_q;
    if (Wr_En) begin
      case (Addr)
        ADDR_MODE_LO:    mode_d[7:0]  = Wr_Data;
        ADDR_MODE_HI:    mode_d[15:8] = Wr_Data;
        ADDR_OUT_STATIC: out_static_d = Wr_Data;
        ADDR_PRESCALE:   prescale_d   = Wr_Data;
        default: begin
          if (is_duty_addr(Addr)) begin
            duty_d[duty_index(Addr)] = Wr_Data;
          end
        end
      endcase
    end
  end

  always_comb begin
    sync1_d = Pin_In;
    sync2_d = sync1_q;
  end

  // Read mux sees pre-write state; a wrap on the read edge is folded into the STATUS value.
  always_comb begin
    rd_mux = '0;
    case (Addr)
      ADDR_MODE_LO:    rd_mux = mode_q[7:0];
      ADDR_MODE_HI:    rd_mux = mode_q[15:8];
      ADDR_OUT_STATIC: rd_mux = out_static_q;
      ADDR_PRESCALE:   rd_mux = prescale_q;
      ADDR_PIN_IN:     rd_mux = sync2_q;
      ADDR_STATUS:     rd_mux = {7'd0, status_q | wrap};
      default: begin
        if (is_duty_addr(Addr)) begin
          rd_mux = duty_q[duty_index(Addr)];
        end
      end
    endcase
  end

  always_comb begin
    rd_valid_d = Rd_En;
    rd_data_d  = Rd_En ? rd_mux : rd_data_q;
    status_d   = status_q;
    if (wrap) begin
      status_d = 1'b1;
    end else if (Rd_En && (Addr == ADDR_STATUS)) begin
      status_d = 1'b0;
    end
  end

  for (genvar g = 0; g < NPINS; g++) begin : g_ch
    gpio_pwm_ctrl_pwm_channel u_ch (
      .Clk           (Clk),
      .Reset         (Reset),
      .duty_shadow_i (duty_q[g]),
      .cnt_i         (cnt_q),
      .wrap_i        (wrap),
      .pwm_o         (pwm[g])
    );
  end

  always_comb begin
    output_d = '0;
    for (int unsigned i = 0; i < NPINS; i++) begin
      unique case (mode_q[2*i +: 2])
        MODE_OUT:           output_d[i] = out_static_q[i];
        MODE_PWM:           output_d[i] = pwm[i];
        MODE_IN, MODE_RSVD: output_d[i] = 1'b0;
        default:            output_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q        <= '0;
      out_static_q  <= '0;
      prescale_q    <= '0;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      duty_q        <= '{default: '0};
      sync1_q       <= '0;
      sync2_q       <= '0;
      status_q      <= 1'b0;
      period_tick_q <= 1'b0;
      output_q      <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      out_static_q  <= out_static_d;
      prescale_q    <= prescale_d;
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      status_q      <= status_d;
      period_tick_q <= period_tick_d;
      output_q      <= output_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign Mode        = mode_q;
  assign Output      = output_q;
  assign Period_Tick = period_tick_q;
  assign Rd_Data     = rd_data_q;
  assign Rd_Valid    = rd_valid_q;

endmodule
